multichan_speed_loop: RTL
=========================

# multichan_speed_loop

Parametrised N-channel closed-loop motor speed regulator that replaces the hand-wired per-wheel loop at top level. Every SAMPLE_CYCLES clocks it runs one sequential sweep over all channels through a single shared multiplier: speed error, proportional correction, and a saturating duty-cycle accumulator. The duty outputs drive the pwm instances directly. After each sweep it can stream a telemetry frame of per-channel errors through a byte-wide handshake to uart_tx.

## Interface
- NUM_CH, 2: number of motor channels (1–8)
- RPM_W, 9: unsigned width of setpoint and measured RPM
- DUTY_W, 16: unsigned duty width, matching pwm R
- KP_W, 16: gain width, unsigned Q(KP_W-8).8
- SAMPLE_CYCLES, 1_000_000: clocks between sweeps (≥ 2*NUM_CH+2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ch_en  in  NUM_CH  per-channel enable, from motor enable switch
- k_p  in  KP_W  proportional gain, Q.8
- rpm_setpoint  in  NUM_CH*RPM_W  packed, channel 0 in the LSBs
- rpm_measured  in  NUM_CH*RPM_W  packed, from tachometer_interface
- duty_out  out  NUM_CH*DUTY_W  packed registered duty per channel
- sat_flag  out  NUM_CH  sticky: the channel's accumulator clamped; cleared by reset only
- sweep_done  out  1  one-cycle pulse at the end of each sweep
- uart_en  in  1  telemetry enable
- tx_start  out  1  one-cycle request to uart_tx
- tx_data  out  8  byte valid while tx_start is high
- tx_done  in  1  uart_tx completion pulse

## Operation
- Tick counter: counts 0..SAMPLE_CYCLES-1 and wraps. The tick is asserted at count SAMPLE_CYCLES-1.
- Sweep FSM states: IDLE → CALC → WRITE → (next channel CALC | DONE) → IDLE.
  - A tick in IDLE latches k_p and resets the channel index to 0.
  - If a tick arrives while not in IDLE, it is dropped. This cannot happen when the SAMPLE_CYCLES constraint is met.
- CALC(i):
  - err = signed(sp[i]) − signed(meas[i]), RPM_W+1 bits, signed.
  - prod = err × k_p, signed at full width.
  - corr = prod >>> 8. The shift is arithmetic and floors toward −∞.
- WRITE(i):
  - sum = duty[i] + corr, computed at full width with no intermediate truncation.
  - If sum < 0, duty = 0. If sum > 2^DUTY_W−1, duty = 2^DUTY_W−1. Otherwise duty = sum.
  - If either clamp fires, sat_flag[i] is set.
  - If ch_en[i] = 0, duty[i] is forced to 0 and no flag is set.
- err8[i] = err clamped to −128..127. It is stored for telemetry during WRITE(i).
- DONE: pulses sweep_done for one cycle.
- Telemetry FSM states: T_IDLE → T_SEND → T_WAIT → (T_SEND | T_IDLE).
  - Starts only if uart_en = 1 at sweep_done and the FSM is in T_IDLE.
  - At start it snapshots all err8 values.
  - If a frame is still in progress, the new frame is skipped; the current frame is never corrupted.
  - Frame format: 0xA5, then err8[0..NUM_CH−1]. Total NUM_CH+1 bytes.
  - T_SEND: tx_start=1 for one cycle with tx_data.
  - T_WAIT: holds until tx_done, then sends the next byte on the following cycle.
  - uart_en going low mid-frame does not abort the frame.

## Timing
- Reset values: duty_out=0, sat_flag=0, sweep_done=0, tx_start=0, tx_data=0. Tick counter=0, both FSMs idle.
- Reset is asynchronous at assertion and takes effect mid-sweep or mid-frame with no partial completion.
- With the tick at cycle T:
  - CALC(i) occupies cycle T+1+2i.
  - duty_out[i] is updated at the edge ending cycle T+2+2i.
  - sweep_done is high in cycle T+2·NUM_CH+1.
- Inputs are sampled in CALC(i). Setpoint and measured values may change at any time. k_p is stable for the whole sweep.
- tx_start is high in the cycle after sweep_done. Each subsequent byte's tx_start comes one cycle after the preceding tx_done.
- Single DSP multiplier, one product per two cycles.

## Test plan
- NUM_CH=2, k_p=0x0080, sp=100/100, meas=60/100, en=11, one tick → duty0 goes 0→20, duty1 stays 0, sweep_done 5 cycles after the tick.
- duty0 preloaded 0xFFF0, k_p=0x0100, err=+100 → duty0=0xFFFF, sat_flag[0]=1 and stays 1 after err returns to 0.
- duty0=10, k_p=0x0100, sp=0, meas=100 → duty0=0. err=−1, k_p=0x0080 → corr=−1 (floor).
- ch_en=01 with err1=+50 → duty1 held 0, sat_flag[1]=0; channel 0 updates normally.
- uart_en=1, err=+200/−3 → bytes 0xA5, 0x7F, 0xFD. Each tx_start waits for tx_done. A second sweep_done mid-frame produces no extra bytes.
- Deassert reset_n mid-sweep and mid-frame → all outputs reset immediately. After release, the first tick occurs at SAMPLE_CYCLES−1.

Source files
------------

// File: rtl/multichan_speed_loop.sv
// N-channel proportional speed regulator: one shared multiplier swept across channels every
// SAMPLE_CYCLES clocks, saturating duty accumulators, and a byte-wide telemetry stream.
module multichan_speed_loop #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned RPM_W         = 9,
    parameter int unsigned DUTY_W        = 16,
    parameter int unsigned KP_W          = 16,
    parameter int unsigned SAMPLE_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [KP_W-1:0]          k_p,
    input  logic [NUM_CH*RPM_W-1:0]  rpm_setpoint,
    input  logic [NUM_CH*RPM_W-1:0]  rpm_measured,
    output logic [NUM_CH*DUTY_W-1:0] duty_out,
    output logic [NUM_CH-1:0]        sat_flag,
    output logic                     sweep_done,
    input  logic                     uart_en,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_done
);

    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int unsigned EW = RPM_W + 1;
    localparam int unsigned PW = EW + KP_W + 1;
    localparam int unsigned SW = ((PW > DUTY_W + 1) ? PW : DUTY_W + 1) + 1;
    localparam int unsigned BW = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StWrite, StDone} sweep_e;
    typedef enum logic [1:0] {TIdle, TSend, TWait} tel_e;

    logic [CW-1:0]            cnt_q;
    logic                     tick;
    sweep_e                   sw_q, sw_d;
    tel_e                     tel_q, tel_d;
    logic [IW-1:0]            idx_q;
    logic                     last_ch;
    logic [KP_W-1:0]          kp_q;
    logic signed [EW-1:0]     err_c, err_q;
    logic signed [PW-1:0]     err_x, kp_x, prod_c, prod_q, corr;
    logic signed [SW-1:0]     corr_x, duty_x, sum, duty_max;
    logic                     en_q;
    logic [DUTY_W-1:0]        duty_new;
    logic                     clamped;
    logic [7:0]               err8_c;
    int                       err_i;
    logic [DUTY_W-1:0]        duty_q [NUM_CH];
    logic [7:0]               err8_q [NUM_CH];
    logic [7:0]               snap_q [NUM_CH];
    logic [NUM_CH-1:0]        sat_q;
    logic [BW-1:0]            bidx_q;

    assign tick    = (cnt_q == CW'(SAMPLE_CYCLES - 1));
    assign last_ch = (idx_q == IW'(NUM_CH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        sw_d = sw_q;
        unique case (sw_q)
            StIdle:  if (tick) sw_d = StCalc;
            StCalc:  sw_d = StWrite;
            StWrite: sw_d = last_ch ? StDone : StCalc;
            StDone:  sw_d = StIdle;
            default: sw_d = StIdle;
        endcase
    end

    // Signed error and full-width product for the channel currently selected.
    always_comb begin
        err_c  = $signed({1'b0, rpm_setpoint[idx_q*RPM_W +: RPM_W]})
               - $signed({1'b0, rpm_measured[idx_q*RPM_W +: RPM_W]});
        err_x  = {{(PW-EW){err_c[EW-1]}}, err_c};
        kp_x   = {{(PW-KP_W){1'b0}}, kp_q};
        prod_c = err_x * kp_x;
    end

    always_comb begin
        corr     = prod_q >>> 8;
        corr_x   = {{(SW-PW){corr[PW-1]}}, corr};
        duty_x   = {{(SW-DUTY_W){1'b0}}, duty_q[idx_q]};
        duty_max = {{(SW-DUTY_W){1'b0}}, {DUTY_W{1'b1}}};
        sum      = duty_x + corr_x;
        duty_new = sum[DUTY_W-1:0];
        clamped  = 1'b0;
        if (sum[SW-1]) begin
            duty_new = '0;
            clamped  = 1'b1;
        end else if (sum > duty_max) begin
            duty_new = '1;
            clamped  = 1'b1;
        end
        err_i  = int'(err_q);
        err8_c = 8'(err_i);
        if (err_i > 127) begin
            err8_c = 8'h7F;
        end else if (err_i < -128) begin
            err8_c = 8'h80;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_q   <= StIdle;
            idx_q  <= '0;
            kp_q   <= '0;
            err_q  <= '0;
            prod_q <= '0;
            en_q   <= 1'b0;
            sat_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= '0;
                err8_q[i] <= '0;
            end
        end else begin
            sw_q <= sw_d;
            if (sw_q == StIdle && tick) begin
                idx_q <= '0;
                kp_q  <= k_p;
            end
            if (sw_q == StCalc) begin
                err_q  <= err_c;
                prod_q <= prod_c;
                en_q   <= ch_en[idx_q];
            end
            if (sw_q == StWrite) begin
                duty_q[idx_q] <= en_q ? duty_new : '0;
                err8_q[idx_q] <= err8_c;
                if (en_q && clamped) sat_q[idx_q] <= 1'b1;
                if (!last_ch) idx_q <= idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        tel_d = tel_q;
        unique case (tel_q)
            TIdle:   if (sweep_done && uart_en) tel_d = TSend;
            TSend:   tel_d = TWait;
            TWait:   if (tx_done) tel_d = (bidx_q == BW'(NUM_CH)) ? TIdle : TSend;
            default: tel_d = TIdle;
        endcase
    end

    // The snapshot decouples an in-flight frame from later sweeps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tel_q  <= TIdle;
            bidx_q <= '0;
            for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
        end else begin
            tel_q <= tel_d;
            if (tel_q == TIdle && sweep_done && uart_en) begin
                snap_q <= err8_q;
                bidx_q <= '0;
            end
            if (tel_q == TWait && tx_done) bidx_q <= bidx_q + 1'b1;
        end
    end

    always_comb begin
        tx_data = '0;
        if (tel_q == TSend) begin
            if (bidx_q == '0) tx_data = 8'hA5;
            for (int i = 0; i < NUM_CH; i++) begin
                if (bidx_q == BW'(i + 1)) tx_data = snap_q[i];
            end
        end
    end

    assign tx_start   = (tel_q == TSend);
    assign sweep_done = (sw_q == StDone);
    assign sat_flag   = sat_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign duty_out[g*DUTY_W +: DUTY_W] = duty_q[g];
    end

endmodule
